// File: rtl/div_unit_pkg.sv
// cpu_consts: shared CPU encodings, including the multiply/divide op type
// and the divider state enum.
`default_nettype none

package cpu_consts;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef struct packed {
    md_op_t md_op;
    logic   word_op;
  } control_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// div_unit_if: request/response handshake bundle between the pipeline and div_unit.
`default_nettype none

interface div_unit_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport slave (
    input  req_valid, req_op, req_word, req_rs1, req_rs2, flush, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_op, req_word, req_rs1, req_rs2, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (DIV/DIVU/REM/REMU and W variants),
// one quotient bit per cycle, with single-cycle fast paths for special cases.
`default_nettype none

module div_unit
  import cpu_consts::*;
#(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = DIV_IDLE;
  localparam logic [1:0] S_CALC = DIV_CALC;
  localparam logic [1:0] S_DONE = DIV_DONE;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;
  logic            r_word;
  logic [XLEN-1:0] r_data;

  logic            w_signed, w_is_rem, w_valid_op;
  logic [XLEN-1:0] w_a, w_b, w_mag_a, w_mag_b, w_min;
  logic            w_neg_a, w_neg_b, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0] w_fast_raw, w_fast_res;

  always_comb begin
    w_valid_op = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU) ||
                 (bus.req_op == OP_REM) || (bus.req_op == OP_REMU);
    w_signed   = (bus.req_op == OP_DIV) || (bus.req_op == OP_REM);
    w_is_rem   = (bus.req_op == OP_REM) || (bus.req_op == OP_REMU);
    if (bus.req_word) begin
      w_a   = w_signed ? sext32(bus.req_rs1[31:0]) : {{(XLEN-32){1'b0}}, bus.req_rs1[31:0]};
      w_b   = w_signed ? sext32(bus.req_rs2[31:0]) : {{(XLEN-32){1'b0}}, bus.req_rs2[31:0]};
      w_min = sext32(32'h8000_0000);
    end else begin
      w_a   = bus.req_rs1;
      w_b   = bus.req_rs2;
      w_min = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_neg_a = w_signed & w_a[XLEN-1];
    w_neg_b = w_signed & w_b[XLEN-1];
    w_mag_a = w_neg_a ? -w_a : w_a;
    w_mag_b = w_neg_b ? -w_b : w_b;
    w_div0  = (w_b == '0);
    w_ovf   = w_signed && (w_a == w_min) && (w_b == '1);
    w_fast  = !w_valid_op || w_div0 || w_ovf;

    w_fast_raw = '0;
    if (w_valid_op && w_div0)
      w_fast_raw = w_is_rem ? w_a : '1;
    else if (w_valid_op && w_ovf)
      w_fast_raw = w_is_rem ? '0 : w_a;
    w_fast_res = bus.req_word ? sext32(w_fast_raw[31:0]) : w_fast_raw;
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [XLEN:0]   w_shift, w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx, w_quot_nx, w_q_fix, w_r_fix, w_res, w_final;

  always_comb begin
    w_shift   = {r_rem, r_quot[XLEN-1]};
    w_sub     = w_shift - {1'b0, r_div};
    w_ge      = !w_sub[XLEN];
    w_rem_nx  = w_ge ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
    w_quot_nx = {r_quot[XLEN-2:0], w_ge};
    w_q_fix   = r_neg_q ? -w_quot_nx : w_quot_nx;
    w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_res     = r_is_rem ? w_r_fix : w_q_fix;
    w_final   = r_word ? sext32(w_res[31:0]) : w_res;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_word   <= 1'b0;
      r_data   <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_is_rem <= w_is_rem;
            r_word   <= bus.req_word;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div    <= w_mag_b;
            r_rem    <= '0;
            if (w_fast) begin
              r_data  <= w_fast_res;
              r_state <= S_DONE;
            end else begin
              // W ops park the 32-bit dividend in the top half so the
              // first 32 steps consume exactly its bits.
              r_quot  <= bus.req_word ? (w_mag_a << 32) : w_mag_a;
              r_cnt   <= bus.req_word ? CW'(32) : CW'(XLEN);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_quot <= w_quot_nx;
          r_rem  <= w_rem_nx;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_data  <= w_final;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.resp_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = (r_state == S_DONE);
  assign bus.resp_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
`default_nettype none

module tb_div_unit;
  import cpu_consts::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  int   lat;
  int   rises;
  logic [63:0] held;

  div_unit_if #(.XLEN(64)) bus ();

  div_unit #(.XLEN(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_word  = w;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts edges from acceptance (inclusive) until resp_valid is seen.
  task automatic wait_resp();
    lat = 1;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int exp_lat);
    start(op, w, a, b);
    wait_resp();
    chk({tag, "_data"}, bus.resp_data, exp);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    consume();
    chk({tag, "_idle"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_word   = 1'b0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_data", bus.resp_data, 64'd0);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run("rem_m7_2", OP_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("div_m7_2", OP_DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("div_5_0", OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu_5_0", OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 1);
    run("divuw", OP_DIVU, 1'b1, 64'hFFFF_FFFF_0000_000A, 64'd3, 64'd3, 33);
    run("divw_ovf", OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run("remw_m7_2", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("bad_op", OP_MUL, 1'b0, 64'd9, 64'd3, 64'd0, 1);

    // Hold the response, then complete it while a new request is waiting.
    start(OP_DIVU, 1'b0, 64'd1000, 64'd10);
    wait_resp();
    chk("stall_lat", 64'(lat), 64'd65);
    held = bus.resp_data;
    chk("stall_data", held, 64'd100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold_data", bus.resp_data, 64'd100);
      chk("stall_hold_valid", {63'd0, bus.resp_valid}, 64'd1);
    end
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_DIVU;
    bus.req_rs1    = 64'd50;
    bus.req_rs2    = 64'd5;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("b2b_not_busy", {63'd0, bus.busy}, 64'd0);
    chk("b2b_req_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("b2b_accept_next", {63'd0, bus.busy}, 64'd1);
    wait_resp();
    chk("b2b_data", bus.resp_data, 64'd10);
    consume();

    // Flush in the 10th CALC cycle.
    start(OP_DIVU, 1'b0, 64'd12345, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) rises++;
    end
    chk("flush_no_resp", 64'(rises), 64'd0);

    // Reset mid-CALC.
    start(OP_DIV, 1'b0, 64'd999, 64'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #2;
    chk("rstcalc_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rstcalc_data", bus.resp_data, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) rises++;
    end
    chk("rstcalc_no_resp", 64'(rises), 64'd0);

    run("after_rst", OP_DIVU, 1'b0, 64'd81, 64'd9, 64'd9, 65);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width in bits.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port resetn, input, 1, meaning reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, meaning a divide request is presented.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit can accept a request; high only in IDLE.
REQ-006 SHALL have port req_op, input, 3, meaning md_op_t operation; only OP_DIV, OP_DIVU, OP_REM and OP_REMU are defined.
REQ-007 SHALL have port req_word, input, 1, meaning a W-variant (32-bit) operation, from control_t.word_op.
REQ-008 SHALL have port req_rs1, input, XLEN, meaning the dividend.
REQ-009 SHALL have port req_rs2, input, XLEN, meaning the divisor.
REQ-010 SHALL have port flush, input, 1, meaning abort any operation in flight.
REQ-011 SHALL have port resp_valid, output, 1, meaning resp_data holds a valid result.
REQ-012 SHALL have port resp_ready, input, 1, meaning the consumer takes the result.
REQ-013 SHALL have port resp_data, output, XLEN, meaning quotient or remainder.
REQ-014 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both high, latching op, word, and both operands.
REQ-017 SHALL transition from IDLE to CALC on acceptance, or from IDLE directly to DONE on a fast-path case.
REQ-018 SHALL iterate one restoring-division step per cycle in CALC, for N=XLEN cycles, or N=32 cycles when word is set, then enter DONE.
REQ-019 SHALL, for a normal operation, first assert resp_valid after the (N+1)th rising edge counting the acceptance edge; fast path asserts it after the acceptance edge.
REQ-020 SHALL take the fast path on divide-by-zero: quotient all ones; remainder equals the dividend.
REQ-021 SHALL take the fast path on signed overflow (most-negative dividend divided by -1): quotient equals the dividend; remainder 0.
REQ-022 SHALL, for a word operation, use the low 32 bits of each operand (sign-extended for signed ops, zero-extended for unsigned ops) and sign-extend the 32-bit result to XLEN.
REQ-023 SHALL, for signed ops, divide magnitudes; negate the quotient when the operand signs differ; give the remainder the dividend's sign.
REQ-024 SHALL treat any other req_op encoding as a fast path returning 0.
REQ-025 SHALL hold resp_valid and resp_data stable in DONE until resp_ready is high, then return to IDLE at that edge.
REQ-026 SHALL NOT accept a new request in the cycle it completes a response; req_ready rises in the next cycle.
REQ-027 SHALL, when flush is high, return to IDLE at the next edge from any state with resp_valid low; flush takes priority over acceptance and completion.
REQ-028 SHALL keep the iteration counter wide enough for count 64 and never wrap within an operation.

Reset
REQ-029 SHALL, while resetn is low, force state to IDLE; resp_valid, resp_data, the counter and all operand registers to 0; req_ready to 1; busy to 0.
REQ-030 SHALL abandon an operation in flight when reset is asserted, producing no response afterwards.

Structure
REQ-031 SHALL reuse md_op_t from cpu_consts and add a div_state_t enum (IDLE, CALC, DONE) to cpu_consts.
REQ-032 SHALL be a single module with no sub-module; sign fix-up and fast-path detection are inline.

Verification
REQ-033 SHALL cover: DIVU rs1=100, rs2=7, word=0 -> resp_data=14, resp_valid after 65 edges.
REQ-034 SHALL cover: REM rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFF; DIV rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD.
REQ-035 SHALL cover: DIV rs1=5, rs2=0 -> all ones; REMU rs1=5, rs2=0 -> 5; DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> 0x8000_0000_0000_0000; all three with 1-edge latency.
REQ-036 SHALL cover: DIVUW rs1=0xFFFF_FFFF_0000_000A, rs2=3 -> 3 after 33 edges; DIVW rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
REQ-037 SHALL cover: resp_ready held low 5 cycles -> resp_data stable; then it returns to IDLE with no back-to-back acceptance on that edge.
REQ-038 SHALL cover: flush at CALC cycle 10, and separately resetn low mid-CALC -> resp_valid never rises; req_ready is high the next cycle.
